// File: rtl/hms_counter_pkg.sv
// Shared types and limits for the hours/minutes/seconds clock.
package hms_pkg;
  localparam int unsigned H_W = 5;
  localparam int unsigned M_W = 6;
  localparam int unsigned S_W = 6;

  localparam logic [H_W-1:0] H_MAX = 5'd23;
  localparam logic [M_W-1:0] M_MAX = 6'd59;
  localparam logic [S_W-1:0] S_MAX = 6'd59;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2
  } mode_e;
endpackage

// File: rtl/hms_counter_if.sv
// Key inputs and time/status outputs of the clock, grouped for benches and wrappers.
interface hms_counter_if;
  import hms_pkg::*;

  logic           key_mode_n;
  logic           key_inc_n;
  logic [H_W-1:0] h;
  logic [M_W-1:0] m;
  logic [S_W-1:0] s;
  logic [1:0]     mode;
  logic           tick;

  modport master (output key_mode_n, key_inc_n, input h, m, s, mode, tick);
  modport slave  (input key_mode_n, key_inc_n, output h, m, s, mode, tick);
endinterface

// File: rtl/hms_counter_key_debounce.sv
// Two-flop synchronizer, level debouncer and single-cycle press pulse for an active-low key.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_key_n,
  output logic o_press
);
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_press;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      // Any sample matching the accepted level restarts the stability count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

// File: rtl/hms_counter.sv
// 24-hour HH:MM:SS clock with prescaler, debounced mode/increment keys and set modes.
module hms_counter
  import hms_pkg::*;
#(
  parameter int unsigned CLK_HZ          = 50_000_000,
  parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           key_mode_n,
  input  logic           key_inc_n,
  output logic [H_W-1:0] h,
  output logic [M_W-1:0] m,
  output logic [S_W-1:0] s,
  output logic [1:0]     mode,
  output logic           tick
);
  localparam int unsigned PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

  logic w_mode_press;
  logic w_inc_press;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (key_mode_n),
    .o_press (w_mode_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk     (clk),
    .rst     (rst),
    .i_key_n (key_inc_n),
    .o_press (w_inc_press)
  );

  mode_e          r_mode, w_mode_nxt;
  logic [H_W-1:0] r_h, w_h_nxt;
  logic [M_W-1:0] r_m, w_m_nxt;
  logic [S_W-1:0] r_s, w_s_nxt;
  logic [PW-1:0]  r_presc, w_presc_nxt;
  logic           r_tick, w_tick_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode  <= RUN;
      r_h     <= '0;
      r_m     <= '0;
      r_s     <= '0;
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_mode  <= w_mode_nxt;
      r_h     <= w_h_nxt;
      r_m     <= w_m_nxt;
      r_s     <= w_s_nxt;
      r_presc <= w_presc_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  always_comb begin
    w_mode_nxt  = r_mode;
    w_h_nxt     = r_h;
    w_m_nxt     = r_m;
    w_s_nxt     = r_s;
    w_presc_nxt = r_presc;
    w_tick_nxt  = 1'b0;
    case (r_mode)
      RUN: begin
        // Leaving RUN takes priority over a coinciding second boundary.
        if (w_mode_press) begin
          w_mode_nxt  = SET_H;
          w_s_nxt     = '0;
          w_presc_nxt = '0;
        end else if (r_presc == PRESC_LAST) begin
          w_presc_nxt = '0;
          w_tick_nxt  = 1'b1;
          if (r_s == S_MAX) begin
            w_s_nxt = '0;
            if (r_m == M_MAX) begin
              w_m_nxt = '0;
              w_h_nxt = (r_h == H_MAX) ? '0 : r_h + 1'b1;
            end else begin
              w_m_nxt = r_m + 1'b1;
            end
          end else begin
            w_s_nxt = r_s + 1'b1;
          end
        end else begin
          w_presc_nxt = r_presc + 1'b1;
        end
      end
      SET_H: begin
        w_presc_nxt = '0;
        w_s_nxt     = '0;
        if (w_mode_press) begin
          w_mode_nxt = SET_M;
        end else if (w_inc_press) begin
          w_h_nxt = (r_h >= H_MAX) ? '0 : r_h + 1'b1;
        end
      end
      SET_M: begin
        w_presc_nxt = '0;
        w_s_nxt     = '0;
        if (w_mode_press) begin
          w_mode_nxt = RUN;
        end else if (w_inc_press) begin
          w_m_nxt = (r_m >= M_MAX) ? '0 : r_m + 1'b1;
        end
      end
      default: begin
        w_mode_nxt  = RUN;
        w_presc_nxt = '0;
      end
    endcase
  end

  assign h    = r_h;
  assign m    = r_m;
  assign s    = r_s;
  assign mode = r_mode;
  assign tick = r_tick;
endmodule
